// File: rtl/pulse_period_meter.sv
// Period meter for an asynchronous input, in prescaled clock ticks.
// Supports averaging, single-shot/continuous modes and saturation.
module pulse_period_meter #(
    parameter int CNT_W    = 10,
    parameter int DIV      = 100,
    parameter int AVG_LOG2 = 0,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PS_W-1:0]  PS_RELOAD = PS_W'(DIV - 1);
    localparam logic [EC_W-1:0]  EC_LAST   = EC_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                rise;

    logic [PS_W-1:0]  pscl_q;
    logic [ACC_W-1:0] acc_q;
    logic [EC_W-1:0]  edge_cnt_q;
    logic             ovf_q;

    logic             measuring;
    logic             tick;
    logic             sat_tick;
    logic             terminal;
    logic             restart;
    logic             finish;
    logic [ACC_W-1:0] acc_tick;

    // Synchroniser chain plus one delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], sig_in};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    assign rise      = sync_q[SYNC_STG-1] & ~prev_q;
    assign measuring = (state_q == MEASURE);
    assign tick      = measuring && (pscl_q == '0);
    assign sat_tick  = tick && (acc_q == ACC_MAX);
    assign terminal  = measuring && rise && (edge_cnt_q == EC_LAST);

    // Accumulator value including a tick landing on the terminal edge
    always_comb begin
        acc_tick = acc_q;
        if (tick && !sat_tick) begin
            acc_tick = acc_q + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; restart opens a new window, finish publishes one
    always_comb begin
        state_nxt = state_q;
        restart   = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    restart   = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (terminal) begin
                    finish = 1'b1;
                    if (continuous) begin
                        restart = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Prescaler: free-runs down from DIV-1 only while measuring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pscl_q <= '0;
        end else if (restart) begin
            pscl_q <= PS_RELOAD;
        end else if (measuring) begin
            if (tick) begin
                pscl_q <= PS_RELOAD;
            end else begin
                pscl_q <= pscl_q - 1'b1;
            end
        end
    end

    // Tick accumulator with saturation and sticky overflow for this window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (restart) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (measuring) begin
            acc_q <= acc_tick;
            if (sat_tick) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Counts bounding edges inside an averaging window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else if (restart) begin
            edge_cnt_q <= '0;
        end else if (measuring && rise) begin
            edge_cnt_q <= edge_cnt_q + 1'b1;
        end
    end

    // Result registers, held until the next published window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= finish;
            if (finish) begin
                period   <= CNT_W'(acc_tick >> AVG_LOG2);
                overflow <= ovf_q | sat_tick;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: three parameter sets share one input;
// results are checked against a window/arithmetic reference model.
module tb_pulse_period_meter;

    localparam int DIVV = 4;

    logic clk;
    logic rst;
    logic sig_in;
    logic start;
    logic continuous;

    logic [7:0] p0;
    logic [7:0] p1;
    logic [3:0] p2;
    logic v0, v1, v2;
    logic o0, o1, o2;
    logic b0, b1, b2;

    typedef struct {
        int     per;
        bit     ovf;
        longint cyc;
    } rec_t;

    rec_t   mq[3][$];
    longint cyc;
    int     n_tests;
    int     n_fail;

    int W[3] = '{8, 8, 4};
    int A[3] = '{0, 2, 0};

    pulse_period_meter #(.CNT_W(8), .DIV(DIVV), .AVG_LOG2(0), .SYNC_STG(2)) u0 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .continuous(continuous), .period(p0), .valid(v0),
        .overflow(o0), .busy(b0)
    );

    pulse_period_meter #(.CNT_W(8), .DIV(DIVV), .AVG_LOG2(2), .SYNC_STG(2)) u1 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .continuous(continuous), .period(p1), .valid(v1),
        .overflow(o1), .busy(b1)
    );

    pulse_period_meter #(.CNT_W(4), .DIV(DIVV), .AVG_LOG2(0), .SYNC_STG(2)) u2 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .continuous(continuous), .period(p2), .valid(v2),
        .overflow(o2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) mq[0].push_back('{int'(p0), o0, cyc});
        if (v1) mq[1].push_back('{int'(p1), o1, cyc});
        if (v2) mq[2].push_back('{int'(p2), o2, cyc});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int get_p(input int i);
        case (i)
            0: return int'(p0);
            1: return int'(p1);
            default: return int'(p2);
        endcase
    endfunction

    function automatic bit get_o(input int i);
        case (i)
            0: return o0;
            1: return o1;
            default: return o2;
        endcase
    endfunction

    function automatic bit get_b(input int i);
        case (i)
            0: return b0;
            1: return b1;
            default: return b2;
        endcase
    endfunction

    function automatic bit get_v(input int i);
        case (i)
            0: return v0;
            1: return v1;
            default: return v2;
        endcase
    endfunction

    task automatic clear_q();
        for (int i = 0; i < 3; i++) mq[i].delete();
    endtask

    // Drive one scenario and compare every instance against the model
    task automatic run_case(input string nm, input int pers[$],
                            input bit cont, input bit skip,
                            input bit do_rst);
        int np;
        int p;
        int rem;
        np = pers.size();
        if (do_rst) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            step(1);
        end
        clear_q();
        sig_in = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        step(2);
        if (skip) begin
            sig_in = 1'b1;
            step(2);
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(10);
            sig_in = 1'b0;
            step(10);
        end else begin
            continuous = cont;
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(4);
        end
        sig_in = 1'b1;
        for (int j = 0; j < np; j++) begin
            p = pers[j];
            step(p / 2);
            sig_in = 1'b0;
            rem = p - p / 2;
            if (cont && j == np - 1) continuous = 1'b0;
            if (j == 0) begin
                start = 1'b1;
                step(1);
                start = 1'b0;
                rem = rem - 1;
            end
            step(rem);
            sig_in = 1'b1;
        end
        step(10);
        sig_in = 1'b0;
        step(20);

        for (int i = 0; i < 3; i++) begin
            int  n;
            int  maxv;
            int  nwin;
            bit  idle;
            int  ep;
            bit  eo;
            n    = 1 << A[i];
            maxv = (1 << (W[i] + A[i])) - 1;
            nwin = cont ? np / n : ((np >= n) ? 1 : 0);
            idle = cont ? (np % n == 0) : (np >= n);
            ep = 0;
            eo = 1'b0;
            n_tests++;
            if (mq[i].size() !== nwin) begin
                n_fail++;
                $display("FAIL %s u%0d valid count: got %0d expected %0d",
                         nm, i, mq[i].size(), nwin);
            end
            for (int w = 0; w < nwin && w < mq[i].size(); w++) begin
                int sum;
                int ticks;
                sum = 0;
                for (int k = 0; k < n; k++) sum += pers[w * n + k];
                ticks = sum / DIVV;
                ep = ((ticks > maxv) ? maxv : ticks) >> A[i];
                eo = (ticks > maxv);
                n_tests++;
                if (mq[i][w].per !== ep || mq[i][w].ovf !== eo) begin
                    n_fail++;
                    $display("FAIL %s u%0d result %0d: got %0d/%0b expected %0d/%0b",
                             nm, i, w, mq[i][w].per, mq[i][w].ovf, ep, eo);
                end
                if (w > 0) begin
                    n_tests++;
                    if (mq[i][w].cyc - mq[i][w-1].cyc !== longint'(sum)) begin
                        n_fail++;
                        $display("FAIL %s u%0d spacing %0d: got %0d expected %0d",
                                 nm, i, w, mq[i][w].cyc - mq[i][w-1].cyc, sum);
                    end
                end
            end
            n_tests++;
            if (get_b(i) !== !idle) begin
                n_fail++;
                $display("FAIL %s u%0d busy: got %0b expected %0b",
                         nm, i, get_b(i), !idle);
            end
            if (nwin > 0 && mq[i].size() == nwin) begin
                n_tests++;
                if (get_p(i) !== ep || get_o(i) !== eo) begin
                    n_fail++;
                    $display("FAIL %s u%0d hold: got %0d/%0b expected %0d/%0b",
                             nm, i, get_p(i), get_o(i), ep, eo);
                end
            end
        end
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (get_p(i) !== 0 || get_v(i) !== 1'b0 ||
                get_o(i) !== 1'b0 || get_b(i) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s u%0d: got p=%0d v=%0b o=%0b b=%0b expected all 0",
                         nm, i, get_p(i), get_v(i), get_o(i), get_b(i));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig_in = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        step(3);
        check_zero("reset_held");
        rst = 1'b0;
        step(3);
        check_zero("reset_release");
    endtask

    task automatic test_single_shot();
        int q[$];
        q = {40, 44, 36, 40};
        run_case("single_fixed", q, 1'b0, 1'b0, 1'b1);
        q.delete();
        for (int j = 0; j < 4; j++) q.push_back(int'($urandom_range(20, 70)));
        run_case("single_rand", q, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        int q[$];
        q = {100, 40};
        run_case("overflow", q, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_continuous();
        int q[$];
        q = {40, 80};
        run_case("cont_fixed", q, 1'b1, 1'b0, 1'b1);
        q.delete();
        for (int j = 0; j < 8; j++) q.push_back(int'($urandom_range(20, 90)));
        run_case("cont_rand", q, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_start_edge();
        int q[$];
        for (int j = 0; j < 4; j++) q.push_back(int'($urandom_range(20, 60)));
        run_case("start_edge", q, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int q[$];
        clear_q();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        sig_in = 1'b1;
        step(20);
        sig_in = 1'b0;
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_mid");
        step(1);
        rst = 1'b0;
        step(2);
        sig_in = 1'b1;
        step(20);
        sig_in = 1'b0;
        step(20);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (mq[i].size() !== 0 || get_b(i) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet u%0d: got %0d valids busy=%0b expected 0/0",
                         i, mq[i].size(), get_b(i));
            end
        end
        q = {40, 40, 48, 32};
        run_case("after_reset", q, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int q[$];
        bit c;
        for (int r = 0; r < 4; r++) begin
            q.delete();
            c = 1'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(1, 9)); j++)
                q.push_back(int'($urandom_range(20, 130)));
            run_case($sformatf("rand%0d", r), q, c, 1'b0, 1'b1);
        end
    endtask

    initial begin
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_single_shot();
        test_overflow();
        test_continuous();
        test_start_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
